// File: rtl/coeff_token_decoder.sv
// CAVLC coeff_token decoder for the 0<=nC<2 and 2<=nC<4 VLC columns, using an iterative leading-zero scan.
// Define COEFF_TOKEN_FLC_NC8_EN to add the 6-bit fixed-length path for nC 8..16.
module coeff_token_decoder #(
    parameter int unsigned WINDOW_W = 16,
    parameter int unsigned LZ_STEP  = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                InValid,
    output logic                InReady,
    input  logic [WINDOW_W-1:0] Bits,
    input  logic [4:0]          nC,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [4:0]          TotalCoeff,
    output logic [1:0]          TrailingOnes,
    output logic [4:0]          NumShift,
    output logic                Error
);
    localparam int unsigned ZC_W     = 5;
    localparam int unsigned N_ENT    = 68;
    localparam int unsigned LZ_LIMIT = 15;

    // Codeword length / value, indexed by TotalCoeff*4 + TrailingOnes; length 0 marks an unused slot
    localparam int unsigned LEN0 [N_ENT] = '{
         1,  0,  0,  0,   6,  2,  0,  0,   8,  6,  3,  0,   9,  8,  7,  5,
        10,  9,  8,  6,  11, 10,  9,  7,  13, 11, 10,  8,  13, 13, 11,  9,
        13, 13, 13, 10,  14, 14, 13, 11,  14, 14, 14, 13,  15, 15, 14, 14,
        15, 15, 15, 14,  16, 15, 15, 15,  16, 16, 16, 15,  16, 16, 16, 16,
        16, 16, 16, 16};
    localparam int unsigned CODE0 [N_ENT] = '{
         1,  0,  0,  0,   5,  1,  0,  0,   7,  4,  1,  0,   7,  6,  5,  3,
         7,  6,  5,  3,   7,  6,  5,  4,  15,  6,  5,  4,  11, 14,  5,  4,
         8, 10, 13,  4,  15, 14,  9,  4,  11, 10, 13, 12,  15, 14,  9, 12,
        11, 10, 13,  8,  15,  1,  9, 12,  11, 14, 13,  8,   7, 10,  9, 12,
         4,  6,  5,  8};
    localparam int unsigned LEN1 [N_ENT] = '{
         2,  0,  0,  0,   6,  2,  0,  0,   6,  5,  3,  0,   7,  6,  6,  4,
         8,  6,  6,  4,   8,  7,  7,  5,   9,  8,  8,  6,  11,  9,  9,  6,
        11, 11, 11,  7,  12, 11, 11,  9,  12, 12, 12, 11,  12, 12, 12, 11,
        13, 13, 13, 12,  13, 13, 13, 13,  13, 14, 13, 13,  14, 14, 14, 13,
        14, 14, 14, 14};
    localparam int unsigned CODE1 [N_ENT] = '{
         3,  0,  0,  0,  11,  2,  0,  0,   7,  7,  3,  0,   7, 10,  9,  5,
         7,  6,  5,  4,   4,  6,  5,  6,   7,  6,  5,  8,  15,  6,  5,  4,
        11, 14, 13,  4,  15, 10,  9,  4,  11, 14, 13, 12,   8, 10,  9,  8,
        15, 14, 13, 12,  11, 10,  9, 12,   7, 11,  6,  8,   9,  8, 10,  1,
         7,  6,  5,  4};

    typedef enum logic [1:0] {IDLE, SCAN, DECODE, OUT} state_t;

    state_t              state_q, state_d;
    logic [WINDOW_W-1:0] win_q, win_d, shifted;
    logic [4:0]          nc_q, nc_d;
    logic [ZC_W-1:0]     zc_q, zc_d, scan_pos, scan_sum, step_sum;
    logic                zerr_q, zerr_d, scan_hit, go_flc;
    logic                out_valid_q, out_valid_d, err_q, err_d, in_ready_q;
    logic [4:0]          tc_q, tc_d, ns_q, ns_d;
    logic [1:0]          t1_q, t1_d;
    logic [LZ_STEP-1:0]  slice;
    logic [15:0]         top16;
    logic                col1, hit;
    logic [6:0]          hit_idx;
    logic [4:0]          hit_len;
    logic [4:0]          res_tc, res_ns;
    logic [1:0]          res_t1;
    logic                res_err;

    // A table entry matches when its leading-zero run equals the scanned count and the whole codeword agrees
    function automatic logic entry_hit(input logic [15:0] top, input logic [ZC_W-1:0] zc,
                                       input int unsigned len, input int unsigned code);
        int unsigned code_w;
        code_w = (code >= 8) ? 4 : (code >= 4) ? 3 : (code >= 2) ? 2 : 1;
        if (len == 0) return 1'b0;
        return ((32'(top) >> (16 - len)) == code) && (32'(zc) == len - code_w);
    endfunction

`ifdef COEFF_TOKEN_FLC_NC8_EN
    logic [3:0] flc_x;
    logic [1:0] flc_y;
    assign flc_x  = win_q[WINDOW_W-1 -: 4];
    assign flc_y  = win_q[WINDOW_W-5 -: 2];
    assign go_flc = (nC >= 5'd8) && (nC <= 5'd16);
`else
    assign go_flc = 1'b0;
`endif

    // Leading-zero scan: first 1 within the next LZ_STEP bits after the counted zeros
    assign shifted  = win_q << zc_q;
    assign slice    = shifted[WINDOW_W-1 -: LZ_STEP];
    assign scan_sum = zc_q + scan_pos;
    assign step_sum = zc_q + ZC_W'(LZ_STEP);

    always_comb begin
        scan_hit = 1'b0;
        scan_pos = '0;
        for (int i = 0; i < int'(LZ_STEP); i++) begin
            if (slice[i]) begin
                scan_hit = 1'b1;
                scan_pos = ZC_W'(int'(LZ_STEP) - 1 - i);
            end
        end
    end

    assign top16 = win_q[WINDOW_W-1 -: 16];
    assign col1  = (nc_q >= 5'd2);

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_len = '0;
        for (int e = 0; e < int'(N_ENT); e++) begin
            if (entry_hit(top16, zc_q, col1 ? LEN1[e] : LEN0[e], col1 ? CODE1[e] : CODE0[e])) begin
                hit     = 1'b1;
                hit_idx = 7'(e);
                hit_len = 5'(col1 ? LEN1[e] : LEN0[e]);
            end
        end
    end

    // Result selection; any failure reports zeros with the error flag
    always_comb begin
        res_err = 1'b1;
        res_tc  = '0;
        res_t1  = '0;
        res_ns  = '0;
        if (nc_q <= 5'd3) begin
            if (!zerr_q && hit) begin
                res_err = 1'b0;
                res_tc  = hit_idx[6:2];
                res_t1  = hit_idx[1:0];
                res_ns  = hit_len;
            end
        end
`ifdef COEFF_TOKEN_FLC_NC8_EN
        else if ((nc_q >= 5'd8) && (nc_q <= 5'd16)) begin
            if (flc_x == 4'd0) begin
                if (flc_y == 2'd3) begin
                    res_err = 1'b0;
                    res_ns  = 5'd6;
                end
            end else if (5'(flc_y) <= 5'(flc_x) + 5'd1) begin
                res_err = 1'b0;
                res_tc  = 5'(flc_x) + 5'd1;
                res_t1  = flc_y;
                res_ns  = 5'd6;
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        nc_d        = nc_q;
        zc_d        = zc_q;
        zerr_d      = zerr_q;
        out_valid_d = out_valid_q;
        tc_d        = tc_q;
        t1_d        = t1_q;
        ns_d        = ns_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (InValid) begin
                    win_d   = Bits;
                    nc_d    = nC;
                    zc_d    = '0;
                    zerr_d  = 1'b0;
                    state_d = go_flc ? DECODE : SCAN;
                end
            end
            SCAN: begin
                if (scan_hit) begin
                    zc_d    = scan_sum;
                    zerr_d  = (scan_sum >= ZC_W'(LZ_LIMIT));
                    state_d = DECODE;
                end else begin
                    zc_d = step_sum;
                    if (step_sum >= ZC_W'(LZ_LIMIT)) begin
                        zerr_d  = 1'b1;
                        state_d = DECODE;
                    end
                end
            end
            DECODE: begin
                tc_d        = res_tc;
                t1_d        = res_t1;
                ns_d        = res_ns;
                err_d       = res_err;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (OutReady) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            win_q       <= '0;
            nc_q        <= '0;
            zc_q        <= '0;
            zerr_q      <= 1'b0;
            out_valid_q <= 1'b0;
            tc_q        <= '0;
            t1_q        <= '0;
            ns_q        <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            nc_q        <= nc_d;
            zc_q        <= zc_d;
            zerr_q      <= zerr_d;
            out_valid_q <= out_valid_d;
            tc_q        <= tc_d;
            t1_q        <= t1_d;
            ns_q        <= ns_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == IDLE);
        end
    end

    assign InReady      = in_ready_q;
    assign OutValid     = out_valid_q;
    assign TotalCoeff   = tc_q;
    assign TrailingOnes = t1_q;
    assign NumShift     = ns_q;
    assign Error        = err_q;

endmodule

// File: tb/tb_coeff_token_decoder.sv
// Bench for coeff_token_decoder: directed vector table, backpressure and reset sequences, and
// randomized codewords built by an encoder-side model, on LZ_STEP=4 and LZ_STEP=1 instances.
module tb_coeff_token_decoder;
    localparam int unsigned STEP_A = 4;
    localparam int unsigned STEP_B = 1;

    localparam int unsigned LEN0 [68] = '{
         1,  0,  0,  0,   6,  2,  0,  0,   8,  6,  3,  0,   9,  8,  7,  5,
        10,  9,  8,  6,  11, 10,  9,  7,  13, 11, 10,  8,  13, 13, 11,  9,
        13, 13, 13, 10,  14, 14, 13, 11,  14, 14, 14, 13,  15, 15, 14, 14,
        15, 15, 15, 14,  16, 15, 15, 15,  16, 16, 16, 15,  16, 16, 16, 16,
        16, 16, 16, 16};
    localparam int unsigned CODE0 [68] = '{
         1,  0,  0,  0,   5,  1,  0,  0,   7,  4,  1,  0,   7,  6,  5,  3,
         7,  6,  5,  3,   7,  6,  5,  4,  15,  6,  5,  4,  11, 14,  5,  4,
         8, 10, 13,  4,  15, 14,  9,  4,  11, 10, 13, 12,  15, 14,  9, 12,
        11, 10, 13,  8,  15,  1,  9, 12,  11, 14, 13,  8,   7, 10,  9, 12,
         4,  6,  5,  8};
    localparam int unsigned LEN1 [68] = '{
         2,  0,  0,  0,   6,  2,  0,  0,   6,  5,  3,  0,   7,  6,  6,  4,
         8,  6,  6,  4,   8,  7,  7,  5,   9,  8,  8,  6,  11,  9,  9,  6,
        11, 11, 11,  7,  12, 11, 11,  9,  12, 12, 12, 11,  12, 12, 12, 11,
        13, 13, 13, 12,  13, 13, 13, 13,  13, 14, 13, 13,  14, 14, 14, 13,
        14, 14, 14, 14};
    localparam int unsigned CODE1 [68] = '{
         3,  0,  0,  0,  11,  2,  0,  0,   7,  7,  3,  0,   7, 10,  9,  5,
         7,  6,  5,  4,   4,  6,  5,  6,   7,  6,  5,  8,  15,  6,  5,  4,
        11, 14, 13,  4,  15, 10,  9,  4,  11, 14, 13, 12,   8, 10,  9,  8,
        15, 14, 13, 12,  11, 10,  9, 12,   7, 11,  6,  8,   9,  8, 10,  1,
         7,  6,  5,  4};

    typedef struct packed {
        logic [4:0] tc;
        logic [1:0] t1;
        logic [4:0] ns;
        logic       err;
    } res_t;

    typedef struct {
        string      name;
        int         d;
        logic [15:0] w;
        logic [4:0] n;
        res_t       exp;
        int         lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] bits;
    logic [4:0]  nc;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [4:0]  tc        [2];
    logic [1:0]  t1        [2];
    logic [4:0]  ns        [2];
    logic        err       [2];

    int checks   = 0;
    int failures = 0;

    coeff_token_decoder #(.WINDOW_W(16), .LZ_STEP(STEP_A)) dut_a (
        .Clk(clk), .Rst_n(rst_n), .InValid(in_valid[0]), .InReady(in_ready[0]),
        .Bits(bits), .nC(nc), .OutValid(out_valid[0]), .OutReady(out_ready[0]),
        .TotalCoeff(tc[0]), .TrailingOnes(t1[0]), .NumShift(ns[0]), .Error(err[0]));

    coeff_token_decoder #(.WINDOW_W(16), .LZ_STEP(STEP_B)) dut_b (
        .Clk(clk), .Rst_n(rst_n), .InValid(in_valid[1]), .InReady(in_ready[1]),
        .Bits(bits), .nC(nc), .OutValid(out_valid[1]), .OutReady(out_ready[1]),
        .TotalCoeff(tc[1]), .TrailingOnes(t1[1]), .NumShift(ns[1]), .Error(err[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic res_t mk(input int tcv, input int t1v, input int nsv, input int errv);
        res_t r;
        r.tc  = 5'(tcv);
        r.t1  = 2'(t1v);
        r.ns  = 5'(nsv);
        r.err = 1'(errv);
        return r;
    endfunction

    // Reference decode: find the table codeword that is a prefix of the window
    function automatic res_t model(input logic [15:0] w, input logic [4:0] n);
        res_t r;
        r = mk(0, 0, 0, 1);
        if (n <= 5'd3) begin
            for (int e = 0; e < 68; e++) begin
                int unsigned len;
                int unsigned code;
                len  = (n >= 5'd2) ? LEN1[e] : LEN0[e];
                code = (n >= 5'd2) ? CODE1[e] : CODE0[e];
                if (len != 0 && (32'(w) >> (16 - len)) == code) r = mk(e / 4, e % 4, int'(len), 0);
            end
        end
`ifdef COEFF_TOKEN_FLC_NC8_EN
        else if (n >= 5'd8 && n <= 5'd16) begin
            int x;
            int y;
            x = int'(w[15:12]);
            y = int'(w[11:10]);
            if (x == 0 && y == 3) r = mk(0, 0, 6, 0);
            else if (x != 0 && y <= x + 1) r = mk(x + 1, y, 6, 0);
        end
`endif
        return r;
    endfunction

    // Edges from acceptance to OutValid
    function automatic int exp_lat(input logic [15:0] w, input logic [4:0] n, input int step);
        int lz;
        lz = 0;
`ifdef COEFF_TOKEN_FLC_NC8_EN
        if (n >= 5'd8 && n <= 5'd16) return 1;
`else
        if (n == 5'd31) lz = 0;
`endif
        while (lz < 16 && w[15-lz] == 1'b0) lz++;
        if (lz < 15) return lz / step + 2;
        return (15 + step - 1) / step + 1;
    endfunction

    task automatic run_one(input string tag, input int d, input logic [15:0] w, input logic [4:0] n,
                           input res_t exp, input int lat_exp, input int stall);
        int lat;
        @(negedge clk);
        check({tag, " in_ready_idle"}, int'(in_ready[d]), 1);
        bits        = w;
        nc          = n;
        in_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        check({tag, " in_ready_busy"}, int'(in_ready[d]), 0);
        lat = 1;
        while (!out_valid[d] && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid[d]) begin
            check({tag, " timeout"}, 0, 1);
        end else begin
            check({tag, " latency"}, lat - 1, lat_exp);
            check({tag, " tc"}, int'(tc[d]), int'(exp.tc));
            check({tag, " t1"}, int'(t1[d]), int'(exp.t1));
            check({tag, " ns"}, int'(ns[d]), int'(exp.ns));
            check({tag, " err"}, int'(err[d]), int'(exp.err));
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                #1;
                check({tag, " hold_valid"}, int'(out_valid[d]), 1);
                check({tag, " hold_tc"}, int'(tc[d]), int'(exp.tc));
                check({tag, " hold_ns"}, int'(ns[d]), int'(exp.ns));
                check({tag, " hold_in_ready"}, int'(in_ready[d]), 0);
            end
            @(negedge clk);
            out_ready[d] = 1'b1;
            @(posedge clk);
            #1;
            out_ready[d] = 1'b0;
            check({tag, " valid_drop"}, int'(out_valid[d]), 0);
            check({tag, " in_ready_back"}, int'(in_ready[d]), 1);
        end
    endtask

    initial begin
        vec_t vecs[$];
        rst_n = 1'b0;
        bits  = '0;
        nc    = '0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset out_valid", int'(out_valid[d]), 0);
            check("reset tc", int'(tc[d]), 0);
            check("reset t1", int'(t1[d]), 0);
            check("reset ns", int'(ns[d]), 0);
            check("reset err", int'(err[d]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset in_ready_a", int'(in_ready[0]), 1);
        check("post_reset in_ready_b", int'(in_ready[1]), 1);

        vecs.push_back('{"one_nc0",      0, 16'h8000, 5'd0,  mk(0, 0, 1, 0),  2});
        vecs.push_back('{"c0000101",     0, 16'h0A00, 5'd1,  mk(3, 2, 7, 0),  3});
        vecs.push_back('{"c0000101_s1",  1, 16'h0A00, 5'd1,  mk(3, 2, 7, 0),  6});
        vecs.push_back('{"c000011x",     0, 16'h0E00, 5'd0,  mk(4, 3, 6, 0),  3});
        vecs.push_back('{"c0000100",     0, 16'h0800, 5'd0,  mk(5, 3, 7, 0),  3});
        vecs.push_back('{"c11_nc2",      0, 16'hC000, 5'd2,  mk(0, 0, 2, 0),  2});
        vecs.push_back('{"c0101_nc2",    0, 16'h5000, 5'd2,  mk(3, 3, 4, 0),  2});
        vecs.push_back('{"nc5_err",      0, 16'h8000, 5'd5,  mk(0, 0, 0, 1),  2});
        vecs.push_back('{"zeros_err",    0, 16'h0000, 5'd0,  mk(0, 0, 0, 1),  5});
        vecs.push_back('{"zeros_err_s1", 1, 16'h0000, 5'd3,  mk(0, 0, 0, 1), 16});
        vecs.push_back('{"nc20_err",     0, 16'h8000, 5'd20, mk(0, 0, 0, 1),  2});
        vecs.push_back('{"lz14_nc1",     0, 16'h0002, 5'd1,  mk(13, 1, 15, 0), 5});
        vecs.push_back('{"lz14_nc1_s1",  1, 16'h0002, 5'd1,  mk(13, 1, 15, 0), 16});
        vecs.push_back('{"unmatched_nc2", 0, 16'h0002, 5'd2, mk(0, 0, 0, 1),  5});
        vecs.push_back('{"tail_ignored", 0, 16'hFFFF, 5'd0,  mk(0, 0, 1, 0),  2});
`ifdef COEFF_TOKEN_FLC_NC8_EN
        vecs.push_back('{"flc_nc10",     0, 16'h5800, 5'd10, mk(6, 2, 6, 0),  1});
        vecs.push_back('{"flc_000011",   1, 16'h0C00, 5'd16, mk(0, 0, 6, 0),  1});
        vecs.push_back('{"flc_000001",   0, 16'h0400, 5'd8,  mk(0, 0, 0, 1),  1});
`else
        vecs.push_back('{"nc10_err",     0, 16'h5800, 5'd10, mk(0, 0, 0, 1),  2});
`endif
        foreach (vecs[i]) run_one(vecs[i].name, vecs[i].d, vecs[i].w, vecs[i].n, vecs[i].exp, vecs[i].lat, 0);

        run_one("backpressure", 0, 16'h0A00, 5'd1, mk(3, 2, 7, 0), 3, 5);

        // Reset while scanning an all-zero window
        @(negedge clk);
        bits        = 16'h0000;
        nc          = 5'd0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("midreset out_valid", int'(out_valid[0]), 0);
        check("midreset in_ready", int'(in_ready[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check("after_reset no_result", int'(out_valid[0]), 0);
        end
        check("after_reset in_ready", int'(in_ready[0]), 1);
        run_one("recover", 0, 16'h5000, 5'd3, mk(3, 3, 4, 0), 2, 0);

        // Randomized: encoded codewords plus raw windows with a random leading-zero run
        for (int i = 0; i < 300; i++) begin
            int d;
            int step;
            logic [15:0] w;
            logic [4:0] n;
            res_t exp;
            d    = (i % 3 == 2) ? 1 : 0;
            step = (d == 0) ? int'(STEP_A) : int'(STEP_B);
            n    = 5'($urandom_range(0, 20));
            if (n <= 5'd3 && $urandom_range(0, 3) != 0) begin
                int tcv;
                int t1v;
                int unsigned len;
                int unsigned code;
                tcv  = int'($urandom_range(0, 16));
                t1v  = int'($urandom_range(0, (tcv < 3) ? tcv : 3));
                len  = (n >= 5'd2) ? LEN1[tcv*4+t1v] : LEN0[tcv*4+t1v];
                code = (n >= 5'd2) ? CODE1[tcv*4+t1v] : CODE0[tcv*4+t1v];
                w    = 16'(code << (16 - len)) | (16'($urandom) & (16'hFFFF >> len));
                exp  = mk(tcv, t1v, int'(len), 0);
            end else begin
                w   = 16'($urandom) >> $urandom_range(0, 16);
                exp = model(w, n);
            end
            run_one("random", d, w, n, exp, exp_lat(w, n, step), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coeff_token_decoder.md
Name: coeff_token_decoder

Overview:
- Multi-cycle CAVLC coeff_token decoder.
- Takes a left-aligned bitstream window and nC, and returns TotalCoeff, TrailingOnes and the consumed codeword length (NumShift) for the bit-shifter.
- Succeeds the fixed single-range combinational LUT slices. Covers table classes 0<=nC<2 and 2<=nC<4 via an iterative leading-zero scan with a parametrised step.
- Uses valid/ready handshakes on both sides. Sits between the bitstream aligner and the level/run decode stages.

Parameters:
- WINDOW_W, 16, input window width in bits (MSB = next bitstream bit); must be >=16.
- LZ_STEP, 4, bits examined per SCAN cycle; legal values 1, 2, 4, 8, 16.

Ports:
- Clk  input  1  clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- InValid  input  1  window/nC valid.
- InReady  output  1  decoder can accept; high only in IDLE.
- Bits  input  WINDOW_W  bitstream window, MSB first.
- nC  input  5  predicted coefficient count, 0..16.
- OutValid  output  1  result valid; held until accepted.
- OutReady  input  1  downstream accepts result.
- TotalCoeff  output  5  decoded total coefficients.
- TrailingOnes  output  2  decoded trailing ones.
- NumShift  output  5  codeword length in bits.
- Error  output  1  unsupported nC or illegal/unmatched codeword.

Behaviour:
- Asynchronous reset (Rst_n low):
  - state=IDLE.
  - OutValid=0, TotalCoeff=0, TrailingOnes=0, NumShift=0, Error=0, internal zero count=0.
  - InReady=1 once reset deasserts.
- FSM states: IDLE, SCAN, DECODE, OUT.
- IDLE:
  - InReady=1.
  - On InValid at a clock edge, register Bits and nC, clear the zero count, and go to SCAN.
  - Exception: with the FLC path enabled and nC>=8, go directly to DECODE.
- SCAN:
  - Each cycle, examine the next LZ_STEP window bits following the already-counted zeros.
  - If a 1 is present: zero count += position of the first 1; go to DECODE.
  - Otherwise: zero count += LZ_STEP, stay in SCAN.
  - If the zero count reaches 15 with no 1 found, go to DECODE with an error flag set.
  - SCAN cycles = floor(lz/LZ_STEP)+1.
- DECODE (one cycle):
  - Use the zero count plus the bits following the leading 1 to select the entry from H.264 Table 9-5: column 0<=nC<2 for nC 0..1, column 2<=nC<4 for nC 2..3.
  - Register TotalCoeff, TrailingOnes, NumShift=codeword length and Error; set OutValid=1; go to OUT.
- OUT:
  - Outputs are stable while OutValid=1 and OutReady=0.
  - When OutValid and OutReady are both high at an edge: clear OutValid and return to IDLE.
  - A new input can be accepted no earlier than the following edge; there is no overlap.
- Latency:
  - Acceptance edge to OutValid high = SCAN cycles + 1 edges.
  - Example: codeword "1" with LZ_STEP=4 gives OutValid 2 edges after acceptance.
- Error cases (result delivered normally with Error=1, TotalCoeff=0, TrailingOnes=0, NumShift=0):
  - nC 4..7.
  - nC>=8 when the FLC path is not compiled in.
  - nC>16.
  - No 1 within the first 15 bits.
  - Bit pattern absent from the selected table column.
- Bits beyond NumShift are ignored.
- InValid while not in IDLE is ignored; the upstream holds it per handshake.
- Reset mid-operation: immediately returns to IDLE with all outputs cleared; any in-flight result is discarded.

Optional Feature:
- Macro: COEFF_TOKEN_FLC_NC8_EN.
- Defined:
  - nC 8..16 uses the 6-bit fixed-length code and bypasses SCAN, so OutValid appears 1 edge after acceptance.
  - Codeword xxxxyy gives TotalCoeff=xxxx+1 and TrailingOnes=yy; "000011" gives TotalCoeff=0, TrailingOnes=0.
  - NumShift=6.
  - The FLC patterns "0000yy" with yy!=11 and the patterns with yy>xxxx+1 raise Error.
- Undefined: nC>=8 raises Error after one DECODE cycle.

Test Plan:
- nC=0, Bits=16'b1xxx..., LZ_STEP=4 -> OutValid 2 edges after accept; TotalCoeff=0, TrailingOnes=0, NumShift=1, Error=0.
- nC=1, Bits=0000101 then zeros -> TotalCoeff=3, TrailingOnes=2, NumShift=7; with LZ_STEP=1 -> 5 SCAN cycles (lz=4), OutValid 6 edges after accept.
- nC=0, Bits=000011x... -> TotalCoeff=4, TrailingOnes=3, NumShift=6. Bits=0000100... -> TotalCoeff=5, TrailingOnes=3, NumShift=7.
- nC=2: Bits=11... -> TotalCoeff=0, TrailingOnes=0, NumShift=2. Bits=0101... -> TotalCoeff=3, TrailingOnes=3, NumShift=4.
- Backpressure: hold OutReady=0 for 5 cycles -> outputs stable, InReady=0 throughout. Assert OutReady -> OutValid drops next edge and InReady returns high.
- nC=5 -> Error=1, TotalCoeff=0, NumShift=0.
- Bits=all zeros, nC=0 -> Error=1.
- With COEFF_TOKEN_FLC_NC8_EN and nC=10, Bits=010110... -> TotalCoeff=6, TrailingOnes=2, NumShift=6, OutValid 1 edge after accept.
- Rst_n pulsed during SCAN -> OutValid=0 and InReady=1 after release.
